// File: rtl/accum_seq.sv
// rtl/accum_seq.sv - burst accumulator sequencing an external 5-bit adder
//
// Sums BURST_LEN unsigned 4-bit operands per burst using an external
// combinational 5-bit adder (add_a + add_b + add_cin -> add_sum, add_cout).
// Optional feature: define ACCUM_SAT_EN to saturate the total at 31 on carry-out;
// without it the total wraps modulo 32. Overflow is flagged in both builds.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   start      begins a burst (sampled only in IDLE)
//   in_valid   in_data holds a valid operand
//   in_data    4-bit unsigned operand
//   in_ready   operand accepted this cycle (ACCUM only)
//   add_a      adder operand A = running total
//   add_b      adder operand B = zero-extended in_data
//   add_cin    adder carry-in, always 0
//   add_sum    adder sum returned
//   add_cout   adder carry-out returned
//   result     registered burst total
//   res_valid  one-cycle strobe in DONE
//   overflow   sticky carry-out flag for the current/last burst
//   busy       high in ACCUM and DONE
module accum_seq #(
  parameter int BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [4:0] add_a,
  output logic [4:0] add_b,
  output logic       add_cin,
  input  logic [4:0] add_sum,
  input  logic       add_cout,
  output logic [4:0] result,
  output logic       res_valid,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(BURST_LEN);

  state_t     state;
  logic [4:0] acc;
  logic [3:0] cnt;
  logic [4:0] acc_next;
  logic       beat;

  assign add_a   = acc;
  assign add_b   = {1'b0, in_data};
  assign add_cin = 1'b0;

  // in_ready is a registered copy of (state == ACCUM)
  assign beat = in_valid & in_ready;

`ifdef ACCUM_SAT_EN
  // Once saturated, 31 + anything nonzero carries again and 31 + 0 stays 31,
  // so the total remains pinned at 31 for the rest of the burst.
  assign acc_next = add_cout ? 5'd31 : add_sum;
`else
  assign acc_next = add_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= 5'd0;
      cnt       <= 4'd0;
      result    <= 5'd0;
      overflow  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          res_valid <= 1'b0;
          if (start) begin
            acc      <= 5'd0;
            cnt      <= 4'd0;
            overflow <= 1'b0;
            state    <= ACCUM;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc <= acc_next;
            cnt <= cnt + 4'd1;
            if (add_cout) begin
              overflow <= 1'b1;
            end
            // BURST_LEN <= 15 keeps the 4-bit counter from wrapping
            if (cnt + 4'd1 == LAST) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              res_valid <= 1'b1;
              result    <= acc_next;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_seq.sv
// tb/tb_accum_seq.sv - self-checking bench for accum_seq with scoreboard
module tb_accum_seq;

  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [4:0] add_a, add_b, add_sum, result;
  logic       add_cin, add_cout, res_valid, overflow, busy;

  logic       start1, in_valid1;
  logic [3:0] in_data1;
  logic       in_ready1;
  logic [4:0] add_a1, add_b1, add_sum1, result1;
  logic       add_cin1, add_cout1, res_valid1, overflow1, busy1;

  int total = 0;
  int bad   = 0;
  logic [5:0] sb_q[$];
  logic       prev_rv = 1'b0;

  always #5 clk = ~clk;

  // external adder models
  assign {add_cout, add_sum}   = {1'b0, add_a}  + {1'b0, add_b}  + {5'b0, add_cin};
  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {5'b0, add_cin1};

  accum_seq #(.BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .result(result),
    .res_valid(res_valid), .overflow(overflow), .busy(busy)
  );

  accum_seq #(.BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1), .result(result1),
    .res_valid(res_valid1), .overflow(overflow1), .busy(busy1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // reference total over the first n beats: {overflow, acc}
  function automatic logic [5:0] model(input logic [3:0] b[4], input int n);
    int  acc = 0;
    logic ov = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc = acc + int'(b[i]);
      if (acc > 31) begin
        ov = 1'b1;
`ifdef ACCUM_SAT_EN
        acc = 31;
`else
        acc = acc - 32;
`endif
      end
    end
    return {ov, 5'(acc)};
  endfunction

  // scoreboard consumer
  always @(negedge clk) begin
    if (res_valid) begin
      check_val("rv_single_cycle", prev_rv, 0);
      check_val("busy_in_done", busy, 1);
      if (sb_q.size() == 0) begin
        check_val("unexpected_result", 1, 0);
      end else begin
        logic [5:0] e;
        e = sb_q.pop_front();
        check_val("result", result, e[4:0]);
        check_val("overflow", overflow, e[5]);
      end
    end
    prev_rv = res_valid;
  end

  task automatic send_beat(input logic [3:0] d, input logic also_start);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    start    = also_start;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check_val("beat_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_burst(input logic [3:0] b[4], input int gap, input logic pulse_start);
    logic [5:0] part;
    sb_q.push_back(model(b, 4));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_beat(b[i], pulse_start);
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          part = model(b, i + 1);
          check_val("gap_acc_hold", add_a, part[4:0]);
          check_val("gap_no_done", res_valid, 0);
          @(posedge clk); #1;
        end
      end
    end
    // now in DONE; a start here must be ignored
    if (pulse_start) start = 1'b1;
    @(negedge clk);
    check_val("done_rv", res_valid, 1);
    check_val("done_in_ready", in_ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_val("idle_rv", res_valid, 0);
    check_val("idle_busy", busy, 0);
    part = model(b, 4);
    check_val("idle_result_hold", result, part[4:0]);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] b1[4] = '{4'd3, 4'd5, 4'd7, 4'd9};
    logic [3:0] b2[4] = '{4'd15, 4'd15, 4'd15, 4'd15};
    logic [3:0] b3[4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    logic [3:0] b4[4] = '{4'd1, 4'd1, 4'd1, 4'd1};
    logic [3:0] b5[4] = '{4'd2, 4'd4, 4'd6, 4'd8};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 4'd0;
    start1 = 1'b0; in_valid1 = 1'b0; in_data1 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_val("rst_result", result, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_res_valid", res_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_acc", add_a, 0);
    check_val("rst_cin", add_cin, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    check_val("exp_24", model(b1, 4), 6'd24);
    run_burst(b1, 0, 1'b0);
    run_burst(b2, 0, 1'b0);
    run_burst(b3, 2, 1'b0);

    // abort mid-burst; rst outranks in_valid and start in the same cycle
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_beat(4'd1, 1'b0);
    send_beat(4'd2, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_data = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    check_val("abort_busy", busy, 0);
    check_val("abort_in_ready", in_ready, 0);
    check_val("abort_result", result, 0);
    check_val("abort_acc", add_a, 0);
    check_val("abort_overflow", overflow, 0);
    @(posedge clk); #1;
    run_burst(b4, 0, 1'b0);

    run_burst(b5, 0, 1'b1);

    // single-beat burst
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 4'd6;
    @(negedge clk);
    check_val("b1_in_ready", in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    check_val("b1_res_valid", res_valid1, 1);
    check_val("b1_result", result1, 6);
    check_val("b1_overflow", overflow1, 0);
    @(negedge clk);
    check_val("b1_rv_low", res_valid1, 0);
    check_val("b1_busy_low", busy1, 0);

    repeat (3) @(posedge clk);
    check_val("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accum_seq.md
ACCUM_SEQ -- requirements
Module: accum_seq

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4: number of 4-bit operands summed per burst; legal range 1..15.
REQ-002 SHALL have one clock; reset is synchronous and active-high. Ports: clk (input, 1 bit), the clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst (input, 1 bit): synchronous, active-high reset.
REQ-004 SHALL have port start (input, 1 bit): begins a burst; sampled only in IDLE.
REQ-005 SHALL have port in_valid (input, 1 bit): in_data holds a valid operand.
REQ-006 SHALL have port in_data (input, 4 bits): unsigned operand.
REQ-007 SHALL have port in_ready (output, 1 bit): block accepts an operand this cycle.
REQ-008 SHALL have ports add_a and add_b (outputs, 5 bits each) and add_cin (output, 1 bit): operands driven to the external 5-bit ripple adder.
REQ-009 SHALL have ports add_sum (input, 5 bits) and add_cout (input, 1 bit): result returned by the external adder; treated as combinational from add_a/add_b/add_cin.
REQ-010 SHALL have port result (output, 5 bits): registered burst total.
REQ-011 SHALL have ports res_valid (output, 1 bit), overflow (output, 1 bit) and busy (output, 1 bit).

Function
REQ-012 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-013 IDLE: start=1 SHALL clear acc, beat counter and overflow, then go to ACCUM; start=0 SHALL stay in IDLE.
REQ-014 add_a SHALL equal acc, add_b SHALL equal {0, in_data} and add_cin SHALL be 0 in every state.
REQ-015 in_ready SHALL be 1 only in ACCUM; a beat is accepted when in_valid and in_ready are both 1.
REQ-016 On an accepted beat, acc SHALL load add_sum and the counter SHALL increment; cycles with in_valid=0 SHALL change nothing.
REQ-017 An accepted beat with add_cout=1 SHALL set overflow; overflow SHALL be sticky until the next start or rst.
REQ-018 The accepted beat that makes count equal BURST_LEN SHALL move the FSM to DONE.
REQ-019 DONE SHALL last exactly one cycle with res_valid=1 and result = final acc, then return to IDLE.
REQ-020 result and overflow SHALL hold their values in IDLE until the next start.
REQ-021 busy SHALL be 1 in ACCUM and DONE, and 0 in IDLE.
REQ-022 start SHALL be ignored in ACCUM and DONE.
REQ-023 The beat counter SHALL be 4 bits wide and SHALL never wrap within a burst.

Reset
REQ-024 rst=1 SHALL force IDLE on the next edge, regardless of state, including mid-burst; the partial sum SHALL be discarded.
REQ-025 After reset, result=0, acc=0, counter=0, overflow=0, res_valid=0, busy=0 and in_ready=0.
REQ-026 rst SHALL take priority over start and over in_valid in the same cycle.

Configuration
REQ-027 Macro ACCUM_SAT_EN defined: an accepted beat with add_cout=1 SHALL load acc with 31 and set overflow; acc SHALL remain 31 for the rest of the burst.
REQ-028 Macro ACCUM_SAT_EN undefined: acc SHALL load add_sum (total modulo 32) and overflow SHALL still be set.

Verification
REQ-029 BURST_LEN=4; start, then beats 3, 5, 7, 9 back-to-back -> res_valid for exactly one cycle after the 4th beat; result=24, overflow=0; busy falls on the following cycle.
REQ-030 Beats 15, 15, 15, 15 -> overflow=1; result=28 with ACCUM_SAT_EN undefined, result=31 with it defined.
REQ-031 Beats 1, 2, 3, 4 with in_valid low for 2 cycles between each beat -> result=10; the counter does not advance during the gaps.
REQ-032 rst asserted after the 2nd beat of a burst -> next cycle shows IDLE, result=0 and in_ready=0; a new burst of 1, 1, 1, 1 -> result=4.
REQ-033 start pulsed during ACCUM and during DONE -> no restart and no clearing; result matches the uninterrupted burst.
REQ-034 BURST_LEN=1; start, then a single beat of 6 -> res_valid on the next cycle with result=6.
